// File: rtl/cpu_0_mul_seq_if.sv
// Request/response bundle for the sequential 32x32 multiplier.
// The master drives operands and control; the slave returns status and the product.
interface cpu_0_mul_seq_if;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        signed_op;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    modport master (
        output start, src1, src2, signed_op, flush,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, src1, src2, signed_op, flush,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/cpu_0_mul_seq.sv
// Sequential 32x32->64 multiplier built from one registered 16x16 multiplier.
// Define MUL_SIGNED_EN to honour signed_op (two's-complement high-word correction).
//
// state | meaning
// IDLE  | waiting for start; also holds the done cycle, where start is ignored
// ISSUE | one 16x16 partial product per cycle, counter order 0..3
// DRAIN | accumulate the last partial product
// FIX   | signed correction of the high word (pass-through when unsigned)
// DONE  | register the accumulator into the result and pulse done
module cpu_0_mul_seq (
    input  logic              clk,
    input  logic              reset_n,
    cpu_0_mul_seq_if.slave    mul_if
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sgn;
    logic [63:0] r_acc;
    logic [1:0]  r_cnt;
    logic [31:0] r_mul;
    logic        r_add_en;
    logic [1:0]  r_add_sel;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;

    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic [63:0] w_pp;
    logic [31:0] w_fix_hi;

    // Counter bit 0 picks the half of src1, bit 1 the half of src2.
    assign w_op_a = r_cnt[0] ? r_a[31:16] : r_a[15:0];
    assign w_op_b = r_cnt[1] ? r_b[31:16] : r_b[15:0];

    always_comb begin
        w_pp = 64'd0;
        case (r_add_sel)
            2'd0:    w_pp = {32'd0, r_mul};
            2'd1,
            2'd2:    w_pp = {16'd0, r_mul, 16'd0};
            default: w_pp = {r_mul, 32'd0};
        endcase
    end

`ifdef MUL_SIGNED_EN
    logic [31:0] w_corr;
    assign w_corr   = (r_a[31] ? r_b : 32'd0) + (r_b[31] ? r_a : 32'd0);
    assign w_fix_hi = r_sgn ? (r_acc[63:32] - w_corr) : r_acc[63:32];
`else
    logic w_unused_sgn;
    assign w_unused_sgn = r_sgn;
    assign w_fix_hi     = r_acc[63:32];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_sgn     <= 1'b0;
            r_acc     <= 64'd0;
            r_cnt     <= 2'd0;
            r_mul     <= 32'd0;
            r_add_en  <= 1'b0;
            r_add_sel <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res_lo  <= 32'd0;
            r_res_hi  <= 32'd0;
        end else begin
            r_add_en <= 1'b0;
            r_done   <= 1'b0;
            if (r_state != IDLE && mul_if.flush) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // r_done marks the done cycle: busy still high, start not honoured
                        if (r_done) begin
                            r_busy <= 1'b0;
                        end else if (mul_if.start) begin
                            r_a     <= mul_if.src1;
                            r_b     <= mul_if.src2;
                            r_sgn   <= mul_if.signed_op;
                            r_acc   <= 64'd0;
                            r_cnt   <= 2'd0;
                            r_busy  <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        r_mul     <= w_op_a * w_op_b;
                        r_add_en  <= 1'b1;
                        r_add_sel <= r_cnt;
                        r_cnt     <= r_cnt + 2'd1;
                        if (r_add_en) r_acc <= r_acc + w_pp;
                        if (r_cnt == 2'd3) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        r_acc   <= r_acc + w_pp;
                        r_state <= FIX;
                    end
                    FIX: begin
                        r_acc[63:32] <= w_fix_hi;
                        r_state      <= DONE;
                    end
                    DONE: begin
                        r_res_lo <= r_acc[31:0];
                        r_res_hi <= r_acc[63:32];
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mul_if.busy      = r_busy;
    assign mul_if.done      = r_done;
    assign mul_if.result_lo = r_res_lo;
    assign mul_if.result_hi = r_res_hi;
endmodule

// File: tb/tb_cpu_0_mul_seq.sv
// Directed and randomized checks of cpu_0_mul_seq against a plain 64-bit arithmetic model.
module tb_cpu_0_mul_seq;
    logic clk;
    logic reset_n;
    cpu_0_mul_seq_if mul_if ();

    cpu_0_mul_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mul_if  (mul_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [63:0] prev_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
`ifdef MUL_SIGNED_EN
        if (s) return sa * sb;
`endif
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Starts an op in the current cycle and walks to the cycle after done.
    // With repulse, start is re-asserted in cycle 3 and again from the done cycle on.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [63:0] exp, input bit repulse);
        mul_if.src1 = a;
        mul_if.src2 = b;
        mul_if.signed_op = s;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        chk("busy_c0", {63'd0, mul_if.busy}, 64'd1);
        chk("done_c0", {63'd0, mul_if.done}, 64'd0);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (repulse && k == 3) begin
                mul_if.start = 1'b1;
                mul_if.src1  = $urandom;
            end
            if (k == 4) mul_if.start = 1'b0;
            chk("busy_run", {63'd0, mul_if.busy}, 64'd1);
            if (k < 7) begin
                chk("done_early", {63'd0, mul_if.done}, 64'd0);
            end else begin
                chk("done_c7", {63'd0, mul_if.done}, 64'd1);
                chk("result", {mul_if.result_hi, mul_if.result_lo}, exp);
                prev_res = exp;
                if (repulse) mul_if.start = 1'b1;
            end
        end
        step();
        chk("done_c8", {63'd0, mul_if.done}, 64'd0);
        chk("busy_c8", {63'd0, mul_if.busy}, 64'd0);
        chk("result_hold", {mul_if.result_hi, mul_if.result_lo}, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        n_vec = 0;
        n_err = 0;
        prev_res = 64'd0;
        mul_if.start = 1'b0;
        mul_if.src1 = 32'd0;
        mul_if.src2 = 32'd0;
        mul_if.signed_op = 1'b0;
        mul_if.flush = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        chk("rst_busy", {63'd0, mul_if.busy}, 64'd0);
        chk("rst_done", {63'd0, mul_if.done}, 64'd0);
        chk("rst_result", {mul_if.result_hi, mul_if.result_lo}, 64'd0);
        reset_n = 1'b1;
        step();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
`else
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0);
`endif
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 1'b1);
        // start has stayed high since the done cycle; this op is accepted one cycle later
        run_op(32'd7, 32'd9, 1'b0, 64'd63, 1'b0);

        // flush in cycle 4
        mul_if.src1 = 32'hDEAD_BEEF;
        mul_if.src2 = 32'h0BAD_F00D;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        mul_if.flush = 1'b1;
        step();
        mul_if.flush = 1'b0;
        chk("flush_busy", {63'd0, mul_if.busy}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            chk("flush_nodone", {63'd0, mul_if.done}, 64'd0);
            step();
        end
        chk("flush_result", {mul_if.result_hi, mul_if.result_lo}, prev_res);
        run_op(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);

        // reset in cycle 3
        mul_if.src1 = 32'hCAFE_0001;
        mul_if.src2 = 32'h8000_1234;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, mul_if.busy}, 64'd0);
        chk("midrst_done", {63'd0, mul_if.done}, 64'd0);
        chk("midrst_result", {mul_if.result_hi, mul_if.result_lo}, 64'd0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("postrst_nodone", {63'd0, mul_if.done}, 64'd0);
        end

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 0) a = 32'h8000_0000;
            if (i == 1) b = 32'h8000_0000;
            run_op(a, b, s, model(a, b, s), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
